// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for data_path (fetch/decode/execute).
// Optional build macro CU_SINGLE_STEP_EN adds a 'step' input for one-instruction-per-pulse runs.
module control_unit #(
    parameter int OPCODE_W = 5,
    parameter int CNT_W    = 16
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [31:0]         IR,
    input  logic                mem_ready,
`ifdef CU_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                PCout,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                HIout,
    output logic                LOout,
    output logic                Yout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                running,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             r_pc_done;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic [4:0] w_op;
    logic       w_alu;
    logic       w_hilo;
    logic       w_nop;
    logic       w_halt;
    logic       w_bad;
    logic       w_retire;
    logic       w_go;
    logic [3:0] w_after;
    logic       w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_unused_ir = ^IR[26:0];
    assign w_alu       = (w_op <= 5'h0B);
    assign w_hilo      = (w_op == 5'h0C) || (w_op == 5'h0D);
    assign w_nop       = (w_op == 5'h1E);
    assign w_halt      = (w_op == 5'h1F);
    assign w_bad       = !(w_alu || w_hilo || w_nop || w_halt);

    // The last execute cycle of a completed instruction
    assign w_retire = ((r_state == S_T5) && !w_hilo)
                   || (r_state == S_T6)
                   || ((r_state == S_T3) && w_nop);

`ifdef CU_SINGLE_STEP_EN
    logic r_step_prev;
    assign w_go = step && !r_step_prev;

    // Previous step level for rising-edge detection
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) r_step_prev <= 1'b0;
        else        r_step_prev <= step;
    end

    // Without a step edge the retiring cycle parks in IDLE,
    // where start and a later step edge resume execution.
    assign w_after = w_go ? S_T0 : S_IDLE;
`else
    assign w_go    = 1'b1;
    assign w_after = S_T0;
`endif

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start && w_go) w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   if (mem_ready) w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (w_alu || w_hilo) w_next = S_T4;
                else if (w_nop)      w_next = w_after;
                else                 w_next = S_HALT;
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = w_hilo ? S_T6 : w_after;
            S_T6:   w_next = w_after;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // State, first-T1 flag, sticky illegal flag and retire counter
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_pc_done <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_pc_done <= (r_state == S_T1);
            if ((r_state == S_T3) && w_bad) r_illegal <= 1'b1;
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    // Strobe decode from state and IR only
    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Yout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
        IncPC = 1'b0; Read = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        alu_op = '0;
        unique case (r_state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = !r_pc_done;
                Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (w_alu)  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                if (w_hilo) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            end
            S_T4: begin
                if (w_alu || w_hilo) begin
                    Grc = w_alu; Grb = w_hilo; Rout = 1'b1; Zin = 1'b1;
                    alu_op = OPCODE_W'(w_op);
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_hilo) LOin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
            end
            default: ;
        endcase
    end

    assign running     = (r_state >= S_T0) && (r_state <= S_T6);
    assign halted      = (r_state == S_HALT);
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
